// File: rtl/rc6_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rc6_pkg
// Description : Shared constants, the output serializer state type and a
//               ceiling-log2 helper used to size counters in the RC6 output
//               path.
// Revision    : 1.0 - initial release
// ============================================================================
package rc6_pkg;

    localparam int RC6_BLOCK_W = 128;
    localparam int RC6_WORD_W  = 32;
    localparam int RC6_OUT_W   = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } rc6_ser_state_t;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rc6_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : rc6_out_serializer
// Description : Captures a DATA_W-bit RC6 result block on a load strobe and
//               streams it LSB-first as OUT_W-bit beats over a valid/ack
//               handshake. New blocks are accepted only when idle; loads
//               arriving while busy are dropped and flagged (sticky).
// Ports       : inClk      - clock, rising edge
//               inReset    - asynchronous active-high reset
//               inLoad     - strobe, inData holds a result block
//               inData     - result block
//               outReady   - idle, a load will be accepted
//               outByte    - current beat (0 when idle)
//               outValid   - outByte is valid
//               inAck      - downstream takes the beat this cycle
//               outLast    - current beat is the final beat of the block
//               outOverrun - sticky, a load was discarded while busy
// Revision    : 1.0 - initial release
// ============================================================================
module rc6_out_serializer
    import rc6_pkg::*;
#(
    parameter int DATA_W = RC6_BLOCK_W,
    parameter int OUT_W  = RC6_OUT_W
) (
    input  logic              inClk,
    input  logic              inReset,
    input  logic              inLoad,
    input  logic [DATA_W-1:0] inData,
    output logic              outReady,
    output logic [OUT_W-1:0]  outByte,
    output logic              outValid,
    input  logic              inAck,
    output logic              outLast,
    output logic              outOverrun
);

    localparam int BEATS = DATA_W / OUT_W;
    localparam int CNT_W = clog2(BEATS);
    localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(BEATS - 1);

    rc6_ser_state_t    r_state;
    rc6_ser_state_t    w_next_state;
    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_overrun;
    logic              w_send;
    logic              w_last;
    logic              w_xfer;

    assign w_send = (r_state == ST_SEND);
    assign w_last = w_send && (r_cnt == c_LAST_BEAT);
    assign w_xfer = w_send && inAck;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge inClk or posedge inReset) begin
        if (inReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (inLoad) begin
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_xfer && w_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register, beat counter and sticky overrun flag
    // ------------------------------------------------------------------
    always_ff @(posedge inClk or posedge inReset) begin
        if (inReset) begin
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (inLoad) begin
                    r_shreg <= inData;
                    r_cnt   <= '0;
                end
            end else begin
                // A load while busy, even on the final-transfer cycle, is
                // dropped; the in-flight block is left untouched.
                if (inLoad) begin
                    r_overrun <= 1'b1;
                end
                if (w_xfer) begin
                    if (w_last) begin
                        r_shreg <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_shreg <= r_shreg >> OUT_W;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    // All outputs are decoded from registered state only.
    assign outReady   = (r_state == ST_IDLE);
    assign outValid   = w_send;
    assign outByte    = w_send ? r_shreg[OUT_W-1:0] : '0;
    assign outLast    = w_last;
    assign outOverrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_rc6_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc6_out_serializer
// Description : Scoreboard bench for rc6_out_serializer. A reference model
//               tracks the number of beats still owed and the overrun flag;
//               accepted blocks are expanded into expected beats in a queue
//               that a monitor pops whenever a beat is handed over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc6_out_serializer;

    localparam int BEATS = 16;
    localparam logic [127:0] c_BLK = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    logic         inClk;
    logic         inReset;
    logic         inLoad;
    logic [127:0] inData;
    logic         inAck;
    logic         outReady;
    logic [7:0]   outByte;
    logic         outValid;
    logic         outLast;
    logic         outOverrun;

    rc6_out_serializer #(
        .DATA_W (128),
        .OUT_W  (8)
    ) dut (
        .inClk      (inClk),
        .inReset    (inReset),
        .inLoad     (inLoad),
        .inData     (inData),
        .outReady   (outReady),
        .outByte    (outByte),
        .outValid   (outValid),
        .inAck      (inAck),
        .outLast    (outLast),
        .outOverrun (outOverrun)
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    int         rem     = 0;
    bit         mdl_ovr = 1'b0;
    logic [7:0] byte_q[$];
    bit         last_q[$];
    int         acc_cyc[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic mdl_reset();
        rem     = 0;
        mdl_ovr = 1'b0;
        byte_q.delete();
        last_q.delete();
    endtask

    // Expected beats of a block: byte k of the block, counted from the LSB.
    function automatic void push_block(input logic [127:0] blk);
        for (int k = 0; k < BEATS; k++) begin
            logic [127:0] sh;
            sh = blk >> (8 * k);
            byte_q.push_back(sh[7:0]);
            last_q.push_back(k == BEATS - 1);
        end
    endfunction

    // Model: a block is owed beat-by-beat; loads while owing beats are lost.
    always @(posedge inClk) begin
        cyc++;
        if (!inReset) begin
            if (rem > 0) begin
                if (inLoad) mdl_ovr = 1'b1;
                if (inAck) rem--;
            end else if (inLoad) begin
                push_block(inData);
                rem = BEATS;
                acc_cyc.push_back(cyc);
            end
        end
    end

    // Monitor: compares presented outputs against the model and scoreboard.
    always @(negedge inClk) begin
        if (!inReset) begin
            check("ready", outReady, (rem == 0));
            check("valid", outValid, (rem > 0));
            check("overrun", outOverrun, mdl_ovr);
            if (outValid) begin
                if (byte_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat at cycle %0d: got %0h, expected no beat", cyc, outByte);
                end else begin
                    check("beat", outByte, byte_q[0]);
                    check("last", outLast, last_q[0]);
                    if (inAck) begin
                        void'(byte_q.pop_front());
                        void'(last_q.pop_front());
                    end
                end
            end else begin
                check("idle_byte", outByte, 8'h00);
                check("idle_last", outLast, 1'b0);
            end
        end
    end

    task automatic tick();
        @(posedge inClk);
        #1;
    endtask

    task automatic load(input logic [127:0] blk);
        inData = blk;
        inLoad = 1'b1;
        tick();
        inLoad = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (!outReady && n < lim) begin
            tick();
            n++;
        end
        if (!outReady) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle timeout: got outReady=0, expected 1 within %0d cycles", lim);
        end
    endtask

    initial begin
        inReset = 1'b1;
        inLoad  = 1'b0;
        inAck   = 1'b0;
        inData  = '0;
        mdl_reset();

        // 1. Reset then idle
        repeat (3) tick();
        inReset = 1'b0;
        tick();
        check("rst_ready", outReady, 1'b1);
        check("rst_valid", outValid, 1'b0);
        check("rst_byte", outByte, 8'h00);
        check("rst_last", outLast, 1'b0);
        check("rst_overrun", outOverrun, 1'b0);

        // 2. Basic stream with ack held high
        inAck = 1'b1;
        load(c_BLK);
        wait_idle(40);
        check("basic_drained", byte_q.size(), 0);

        // 3. Backpressure
        load(c_BLK);
        for (int c = 1; c < 40 && !outReady; c++) begin
            inAck = !((c >= 3 && c <= 6) || (c >= 12 && c <= 13));
            tick();
        end
        inAck = 1'b1;
        wait_idle(5);
        check("bp_drained", byte_q.size(), 0);

        // 5. Back-to-back: load-to-load spacing
        acc_cyc.delete();
        load(c_BLK);
        wait_idle(40);
        load(~c_BLK);
        wait_idle(40);
        check("b2b_count", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 17);

        // 4. Overrun: loads at beat 5 and on the final-beat cycle are dropped
        load(128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF);
        repeat (5) tick();
        load(128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF);
        for (int n = 0; n < 40 && !outLast; n++) tick();
        check("ovr_at_last", outLast, 1'b1);
        load(128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF);
        check("ovr_ready_after", outReady, 1'b1);
        check("ovr_flag", outOverrun, 1'b1);
        load(128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF);
        wait_idle(40);
        check("ovr_sticky", outOverrun, 1'b1);
        check("ovr_drained", byte_q.size(), 0);

        // 6. Asynchronous reset mid-block
        load(c_BLK);
        repeat (7) tick();
        #2;
        inReset = 1'b1;
        mdl_reset();
        #1;
        check("arst_valid", outValid, 1'b0);
        check("arst_byte", outByte, 8'h00);
        check("arst_last", outLast, 1'b0);
        check("arst_ready", outReady, 1'b1);
        check("arst_overrun", outOverrun, 1'b0);
        repeat (2) tick();
        inReset = 1'b0;
        repeat (20) tick();
        check("arst_no_residual", outValid, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            inAck  = ($urandom_range(0, 3) != 0);
            inLoad = outReady ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
            inData = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        inLoad = 1'b0;
        inAck  = 1'b1;
        wait_idle(40);
        tick();
        check("rand_drained", byte_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
